// File: rtl/blockade_dn_writer.sv
// blockade_dn_writer: accepts the loader byte stream, remaps file order into the
// 14-bit download address map and drives dn_addr/dn_data/dn_wr toward the game.
// Holds the game in reset until a complete, well-formed 2560-byte image is written.
// Optional feature: define BLOCKADE_DN_CHECKSUM_EN to add an 8-bit modular byte-sum
// check against EXPECTED_SUM.
module blockade_dn_writer #(
    parameter int unsigned WR_GAP       = 2,
    parameter logic [7:0]  EXPECTED_SUM = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic [13:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_reset_hold
);

    typedef enum logic [2:0] {
        StIdle, StSetup, StStrobe, StGap, StWait, StCheck, StDone, StErr
    } state_t;

    localparam logic [11:0] LastIdx = 12'd2559;
    localparam logic [3:0]  GapInit = (WR_GAP > 0) ? 4'(WR_GAP - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [11:0] idx_q;
    logic [3:0]  gap_q;
    logic        last_q;   // captured byte carried s_last
    logic        end_q;    // captured byte was index 2559
    logic        dn_wr_q;
    logic        accept;
    logic        sum_ok;

    assign accept = s_valid && s_ready;

    // File index to board download address: U2, U3, U29, U43 in stream order.
    function automatic logic [13:0] map_addr(input logic [11:0] i);
        logic [13:0] a;
        case (i[11:8])
            4'h8:    a = 14'h1100 | {6'b0, i[7:0]};
            4'h9:    a = 14'h1000 | {6'b0, i[7:0]};
            default: a = i[10] ? {4'b0, i[9:0]} : (14'h0400 | {4'b0, i[9:0]});
        endcase
        return a;
    endfunction

`ifdef BLOCKADE_DN_CHECKSUM_EN
    logic [7:0] sum_q;

    // Running modular sum of every accepted byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= 8'h00;
        end else if (accept) begin
            sum_q <= sum_q + s_data;
        end
    end

    assign sum_ok = (sum_q == EXPECTED_SUM);
`else
    logic unused_expected_sum;
    assign unused_expected_sum = ^EXPECTED_SUM;
    assign sum_ok = 1'b1;
`endif

    // Next-state decode for the load sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StWait: if (accept) state_d = StSetup;
            StSetup:        state_d = StStrobe;
            StStrobe: begin
                // A stream ending early or overrunning index 2559 is settled in CHECK.
                if (last_q || end_q)  state_d = StCheck;
                else if (WR_GAP == 0) state_d = StWait;
                else                  state_d = StGap;
            end
            StGap:          if (gap_q == 4'd0) state_d = StWait;
            StCheck:        state_d = (last_q && end_q && sum_ok) ? StDone : StErr;
            default:        state_d = state_q;
        endcase
    end

    // State, capture registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            idx_q          <= 12'd0;
            gap_q          <= 4'd0;
            last_q         <= 1'b0;
            end_q          <= 1'b0;
            dn_addr        <= 14'd0;
            dn_data        <= 8'd0;
            dn_wr_q        <= 1'b0;
            s_ready        <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            cpu_reset_hold <= 1'b1;
        end else begin
            state_q        <= state_d;
            s_ready        <= (state_d == StIdle) || (state_d == StWait);
            busy           <= !((state_d == StIdle) || (state_d == StDone) || (state_d == StErr));
            done           <= (state_d == StDone);
            error          <= (state_d == StErr);
            cpu_reset_hold <= (state_d != StDone);
            dn_wr_q        <= (state_d == StStrobe);
            if (accept) begin
                dn_addr <= map_addr(idx_q);
                dn_data <= s_data;
                last_q  <= s_last;
                end_q   <= (idx_q == LastIdx);
                if (idx_q != LastIdx) idx_q <= idx_q + 12'd1;
            end
            if (state_q == StStrobe) begin
                gap_q <= GapInit;
            end else if (state_q == StGap && gap_q != 4'd0) begin
                gap_q <= gap_q - 4'd1;
            end
        end
    end

    // Reset kills a strobe already in flight in the same cycle.
    assign dn_wr = dn_wr_q && !reset;

endmodule

// File: tb/tb_blockade_dn_writer.sv
// Directed bench for blockade_dn_writer (default build, WR_GAP = 2).
module tb_blockade_dn_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic [13:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_reset_hold;

    blockade_dn_writer #(.WR_GAP(2), .EXPECTED_SUM(8'h00)) dut (
        .clk            (clk),
        .reset          (reset),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_last         (s_last),
        .s_ready        (s_ready),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .cpu_reset_hold (cpu_reset_hold)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_cyc = 0;
    int strobe_cnt = 0;
    int seq_bad    = 0;
    int space_bad  = 0;
    bit chk_space  = 1'b0;
    logic [13:0] addr_log [0:2559];

    function automatic logic [13:0] exp_addr(input int i);
        if (i < 1024)      return 14'(14'h0400 + i);
        else if (i < 2048) return 14'(i - 1024);
        else if (i < 2304) return 14'(14'h1100 + (i - 2048));
        else               return 14'(14'h1000 + (i - 2304));
    endfunction

    function automatic logic [7:0] pat(input int i);
        return 8'(i) ^ 8'h3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Strobe monitor: logs addresses, compares against the address model, checks spacing.
    always @(negedge clk) begin
        #2;
        if (dn_wr === 1'b1) begin
            if (strobe_cnt < 2560) begin
                addr_log[strobe_cnt] = dn_addr;
                if (dn_addr !== exp_addr(strobe_cnt) || dn_data !== pat(strobe_cnt)) seq_bad++;
            end else begin
                seq_bad++;
            end
            if (chk_space && strobe_cnt > 0 && (cyc - last_cyc) != 5) space_bad++;
            last_cyc = cyc;
            strobe_cnt++;
        end
    end

    task automatic send_byte(input int i, input bit last, input int idle);
        int t;
        s_valid = 1'b0;
        repeat (idle) @(negedge clk);
        s_valid = 1'b1;
        s_data  = pat(i);
        s_last  = last;
        t = 0;
        while (s_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) check("accept_timeout", 32'(s_ready), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_range(input int first, input int n, input int last_at, input bit bursty);
        for (int i = first; i < n; i++) begin
            send_byte(i, (i == last_at), bursty ? int'($urandom_range(0, 2)) : 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        strobe_cnt = 0;
        seq_bad    = 0;
        space_bad  = 0;
    endtask

    task automatic check_idle_values(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
        check({tag, "_dn_addr"}, 32'(dn_addr), 32'd0);
        check({tag, "_dn_data"}, 32'(dn_data), 32'd0);
        check({tag, "_dn_wr"},   32'(dn_wr),   32'd0);
        check({tag, "_busy"},    32'(busy),    32'd0);
        check({tag, "_done"},    32'(done),    32'd0);
        check({tag, "_error"},   32'(error),   32'd0);
        check({tag, "_hold"},    32'(cpu_reset_hold), 32'd1);
    endtask

    task automatic check_done_image(input string tag);
        check({tag, "_strobes"}, 32'(strobe_cnt), 32'd2560);
        check({tag, "_seq_bad"}, 32'(seq_bad), 32'd0);
        check({tag, "_done"},    32'(done), 32'd1);
        check({tag, "_error"},   32'(error), 32'd0);
        check({tag, "_hold"},    32'(cpu_reset_hold), 32'd0);
        check({tag, "_busy"},    32'(busy), 32'd0);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    endtask

    initial begin
        int rdy_seen;
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_values("reset");
        reset = 1'b0;
        @(negedge clk);

        // Full image, source always ready; byte 0 latency checked by hand.
        chk_space = 1'b1;
        send_byte(0, 1'b0, 0);
        #1;
        check("b0_setup_addr",  32'(dn_addr), 32'h0400);
        check("b0_setup_data",  32'(dn_data), 32'h3C);
        check("b0_setup_wr",    32'(dn_wr),   32'd0);
        check("b0_setup_ready", 32'(s_ready), 32'd0);
        check("b0_setup_busy",  32'(busy),    32'd1);
        @(negedge clk);
        #1;
        check("b0_strobe_wr",   32'(dn_wr),   32'd1);
        send_range(1, 2559, -1, 1'b0);
        send_byte(2559, 1'b1, 0);
        @(negedge clk);
        #1;
        check("last_strobe_wr", 32'(dn_wr), 32'd1);
        @(negedge clk);
        #1;
        check("check_not_done", 32'(done), 32'd0);
        @(negedge clk);
        #1;
        check("full_addr_0",    32'(addr_log[0]),    32'h0400);
        check("full_addr_1024", 32'(addr_log[1024]), 32'h0000);
        check("full_addr_2048", 32'(addr_log[2048]), 32'h1100);
        check("full_addr_2559", 32'(addr_log[2559]), 32'h10FF);
        check("full_spacing",   32'(space_bad), 32'd0);
        check_done_image("full");

        // Short image: s_last on byte 99.
        do_reset();
        send_range(0, 100, 99, 1'b0);
        repeat (10) @(negedge clk);
        #1;
        check("short_strobes", 32'(strobe_cnt), 32'd100);
        check("short_addr_99", 32'(addr_log[99]), 32'h0463);
        check("short_seq_bad", 32'(seq_bad), 32'd0);
        check("short_error",   32'(error), 32'd1);
        check("short_done",    32'(done), 32'd0);
        check("short_hold",    32'(cpu_reset_hold), 32'd1);
        check("short_ready",   32'(s_ready), 32'd0);

        // Missing s_last: 2560 bytes, then a 2561st offered that must never be taken.
        do_reset();
        send_range(0, 2560, -1, 1'b0);
        s_valid  = 1'b1;
        s_data   = pat(2560);
        rdy_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (s_ready !== 1'b0) rdy_seen++;
        end
        s_valid = 1'b0;
        #1;
        check("nolast_ready_seen", 32'(rdy_seen), 32'd0);
        check("nolast_strobes",    32'(strobe_cnt), 32'd2560);
        check("nolast_addr_2559",  32'(addr_log[2559]), 32'h10FF);
        check("nolast_error",      32'(error), 32'd1);
        check("nolast_done",       32'(done), 32'd0);

        // Bursty source: random idle gaps before each byte.
        do_reset();
        chk_space = 1'b0;
        send_range(0, 2560, 2559, 1'b1);
        repeat (6) @(negedge clk);
        #1;
        check_done_image("bursty");

        // Reset during the strobe of byte 500, then a clean reload.
        do_reset();
        send_range(0, 501, -1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_strobe_wr", 32'(dn_wr), 32'd0);
        @(negedge clk);
        #1;
        check_idle_values("rst_mid");
        check("rst_strobes", 32'(strobe_cnt), 32'd500);
        reset = 1'b0;
        strobe_cnt = 0;
        seq_bad    = 0;
        space_bad  = 0;
        chk_space  = 1'b1;
        @(negedge clk);
        send_range(0, 2560, 2559, 1'b0);
        repeat (6) @(negedge clk);
        #1;
        check("reload_addr_0",  32'(addr_log[0]), 32'h0400);
        check("reload_spacing", 32'(space_bad), 32'd0);
        check_done_image("reload");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
